message_checker: RTL and testbench

- Reads back the decrypted message RAM that the RC4 decrypt stage writes, one byte at a time.
- Checks that every byte is a legal plaintext character: lowercase 'a'..'z' (8'd97..8'd122) or space (8'd32).
- Reports pass/fail, the index of the first illegal byte, and the number of legal bytes read.
- Serves as the judge for the key-search controller. The controller starts it after each decrypt finishes and uses its verdict to decide whether to try the next key.

---
 rtl/message_checker.sv | 131 +++++++++++++
 tb/tb_message_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/message_checker.sv
// message_checker: reads back the decrypted message RAM one byte at a time
// and judges whether every byte is a legal plaintext character (lowercase
// 'a'..'z' or space). The key-search controller starts it after each
// decrypt pass and uses the verdict to decide whether to try the next key.
//
// Each byte costs three cycles: present the address, wait one dead cycle
// for the RAM's read latency, then sample and judge the data. The first
// illegal byte aborts the scan, so a wrong key is usually rejected early.

module message_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        q_ram,
  output logic [ADDR_W-1:0] address_ram,
  output logic              finish,
  output logic              valid,
  output logic [ADDR_W-1:0] bad_index,
  output logic [ADDR_W:0]   char_count,
  output logic [7:0]        LED
);

  // Scan states
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SET_ADDR = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] CHECK    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  // Index of the final message byte; k stops here so the address never
  // leaves 0..MSG_LEN-1.
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_addr;
  logic              r_finish;
  logic              r_valid;
  logic [ADDR_W-1:0] r_badIndex;
  logic [ADDR_W:0]   r_charCount;
  logic [7:0]        r_led;

  logic              w_isSpace;
  logic              w_isLower;
  logic              w_legal;
  logic              w_lastByte;

  // Legality is an exact range test: space, or 'a'..'z' inclusive.
  assign w_isSpace  = (q_ram == 8'd32);
  assign w_isLower  = (q_ram >= 8'd97) && (q_ram <= 8'd122);
  assign w_legal    = w_isSpace || w_isLower;
  assign w_lastByte = (r_k == LAST_K);

  // Scan sequencer: reset wins over everything, then step through the bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_addr      <= '0;
      r_finish    <= 1'b0;
      r_valid     <= 1'b0;
      r_badIndex  <= '0;
      r_charCount <= '0;
      r_led       <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_finish <= 1'b0;
          if (start) begin
            r_k         <= '0;
            r_charCount <= '0;
            r_valid     <= 1'b0;
            r_badIndex  <= '0;
            r_state     <= SET_ADDR;
          end
        end

        SET_ADDR: begin
          r_addr  <= r_k;
          r_state <= WAIT;
        end

        WAIT: begin
          r_state <= CHECK;
        end

        CHECK: begin
          r_led <= q_ram;
          if (w_legal) begin
            r_charCount <= r_charCount + 1'b1;
            if (w_lastByte) begin
              r_valid  <= 1'b1;
              r_finish <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= SET_ADDR;
            end
          end else begin
            r_valid    <= 1'b0;
            r_badIndex <= r_k;
            r_finish   <= 1'b1;
            r_state    <= DONE;
          end
        end

        DONE: begin
          if (!start) begin
            r_finish <= 1'b0;
            r_state  <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address_ram = r_addr;
  assign finish      = r_finish;
  assign valid       = r_valid;
  assign bad_index   = r_badIndex;
  assign char_count  = r_charCount;
  assign LED         = r_led;

endmodule

// File: tb/tb_message_checker.sv
// Testbench for message_checker: a small RAM model with one cycle of
// registered read, a table of message images with hand-computed verdicts,
// and hand-written sequences for DONE holding, mid-check reset and
// reset/start collisions.

module tb_message_checker;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 8;
  localparam int MAX_EDGES = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        q_ram;
  logic [ADDR_W-1:0] address_ram;
  logic              finish;
  logic              valid;
  logic [ADDR_W-1:0] bad_index;
  logic [ADDR_W:0]   char_count;
  logic [7:0]        LED;

  logic [7:0] mem [0:MSG_LEN-1];

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    string      name;
    int         imageSel;
    int         badPos;
    logic [7:0] badByte;
    int         expEdges;
    int         expValid;
    int         expBad;
    int         expCount;
    int         expLed;
    int         expAddr;
  } vec_t;

  vec_t vecs [8];

  message_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .q_ram(q_ram),
    .address_ram(address_ram),
    .finish(finish),
    .valid(valid),
    .bad_index(bad_index),
    .char_count(char_count),
    .LED(LED)
  );

  always #5 clk = ~clk;

  // RAM read: data appears after the edge following the address change,
  // so the checker sees it on the second edge after driving the address.
  always @(posedge clk) begin
    q_ram <= mem[address_ram[4:0]];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // imageSel 0: alphabet text; 1: alternating space / 'z'. Optional override.
  task automatic loadImage(input int sel, input int pos, input logic [7:0] b);
    string s;
    s = "abcdefghijklmnopqrstuvwxyz abcde";
    for (int i = 0; i < MSG_LEN; i++) begin
      if (sel == 0) mem[i] = s[i];
      else          mem[i] = (i % 2 == 0) ? 8'd32 : 8'd122;
    end
    if (pos >= 0) mem[pos] = b;
  endtask

  // Count edges from the first edge that samples start until finish is seen.
  task automatic runUntilFinish(output int edges, output int maxAddr);
    int n;
    n = 0;
    maxAddr = 0;
    edges = -1;
    while (n < MAX_EDGES) begin
      @(posedge clk);
      n++;
      #1;
      if (n >= 2 && int'(address_ram) > maxAddr) maxAddr = int'(address_ram);
      if (finish) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx);
    int edges;
    int maxAddr;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({vecs[idx].name, " finish idle"}, finish, 0);
    loadImage(vecs[idx].imageSel, vecs[idx].badPos, vecs[idx].badByte);
    start = 1'b1;
    runUntilFinish(edges, maxAddr);
    checkOutput({vecs[idx].name, " finish edge"}, edges, vecs[idx].expEdges);
    checkOutput({vecs[idx].name, " valid"}, valid, vecs[idx].expValid);
    if (vecs[idx].expValid == 0)
      checkOutput({vecs[idx].name, " bad_index"}, bad_index, vecs[idx].expBad);
    checkOutput({vecs[idx].name, " char_count"}, char_count, vecs[idx].expCount);
    checkOutput({vecs[idx].name, " LED"}, LED, vecs[idx].expLed);
    checkOutput({vecs[idx].name, " address_ram"}, address_ram, vecs[idx].expAddr);
    checkOutput({vecs[idx].name, " max address"}, maxAddr, vecs[idx].expAddr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " finish"}, finish, 0);
    checkOutput({tag, " valid"}, valid, 0);
    checkOutput({tag, " bad_index"}, bad_index, 0);
    checkOutput({tag, " char_count"}, char_count, 0);
    checkOutput({tag, " LED"}, LED, 0);
    checkOutput({tag, " address_ram"}, address_ram, 0);
  endtask

  initial begin
    int edges;
    int maxAddr;

    // name, image, badPos, badByte, edges, valid, bad, count, LED, addr
    vecs[0] = '{"alpha ok",    0, -1, 8'd0,   97, 1, 0,  32, 101, 31};
    vecs[1] = '{"upper A@5",   0,  5, 8'd65,  19, 0, 5,  5,  65,  5};
    vecs[2] = '{"bq@0",        0,  0, 8'd96,  4,  0, 0,  0,  96,  0};
    vecs[3] = '{"brace@31",    0, 31, 8'd123, 97, 0, 31, 31, 123, 31};
    vecs[4] = '{"space z ok",  1, -1, 8'd0,   97, 1, 0,  32, 122, 31};
    vecs[5] = '{"nul@10",      0, 10, 8'd0,   34, 0, 10, 10, 0,   10};
    vecs[6] = '{"upper Z@20",  0, 20, 8'd90,  64, 0, 20, 20, 90,  20};
    vecs[7] = '{"bang@26",     0, 26, 8'd33,  82, 0, 26, 26, 33,  26};

    loadImage(0, -1, 8'd0);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // DONE holds while start stays high
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("done hold finish", finish, 1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done release finish", finish, 0);

    // Fresh check restarts char_count from zero
    loadImage(1, -1, 8'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("restart char_count", char_count, 0);
    runUntilFinish(edges, maxAddr);
    checkOutput("restart edges", edges, 96);
    checkOutput("restart valid", valid, 1);
    checkOutput("restart char_count end", char_count, 32);

    // Reset while in WAIT at k=12
    start = 1'b0;
    @(posedge clk);
    #1;
    loadImage(0, -1, 8'd0);
    start = 1'b1;
    repeat (38) @(posedge clk);
    #1;
    checkOutput("midcheck address_ram", address_ram, 12);
    checkOutput("midcheck char_count", char_count, 12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midreset");
    reset = 1'b0;
    runUntilFinish(edges, maxAddr);
    checkOutput("after reset edges", edges, 97);
    checkOutput("after reset valid", valid, 1);
    checkOutput("after reset char_count", char_count, 32);
    checkOutput("after reset LED", LED, 101);

    // Reset and start together in IDLE
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset+start");
    reset = 1'b0;
    runUntilFinish(edges, maxAddr);
    checkOutput("reset+start edges", edges, 97);
    checkOutput("reset+start valid", valid, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
